// File: rtl/tone_oscillator.sv
// Square-wave tone generator: each wave level lasts max_q cycles, and a new
// half-period is picked up from max_i only at the end of a full period.
module tone_oscillator #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic         en_i,
    input  logic [W-1:0] max_i,
    output logic         wave_o,
    output logic         tick_o,
    output logic         busy_o,
    output logic [W-1:0] max_q_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   count, count_nxt;
    logic [W-1:0]   max_q, max_q_nxt;
    logic           wave, wave_nxt;
    logic           tick, tick_nxt;
    logic           last_cnt;

    // max_q >= 1 whenever RUN, so the subtraction cannot wrap where it matters
    assign last_cnt = (count == max_q - W'(1));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
            count <= '0;
            max_q <= '0;
            wave  <= 1'b0;
            tick  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            max_q <= max_q_nxt;
            wave  <= wave_nxt;
            tick  <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        max_q_nxt = max_q;
        wave_nxt  = wave;
        tick_nxt  = 1'b0;
        case (state)
            IDLE: begin
                count_nxt = '0;
                wave_nxt  = 1'b0;
                if (en_i && max_i != '0) begin
                    state_nxt = RUN;
                    max_q_nxt = max_i;
                end
            end
            RUN: begin
                // disable wins over any toggle/reload on the same edge
                if (!en_i) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                    wave_nxt  = 1'b0;
                end else if (last_cnt) begin
                    count_nxt = '0;
                    wave_nxt  = ~wave;
                    if (!wave) begin
                        tick_nxt = 1'b1;
                    end else if (max_i != '0) begin
                        max_q_nxt = max_i;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    count_nxt = count + W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wave_o  = wave;
    assign tick_o  = tick;
    assign busy_o  = (state == RUN);
    assign max_q_o = max_q;

endmodule

// File: tb/tb_tone_oscillator.sv
// Randomized and directed bench for tone_oscillator against a period-position
// reference model.
module tb_tone_oscillator;

    logic        tb_clk = 1'b0;
    logic        nRst;
    logic        en_i;
    logic [19:0] max_i;
    logic        wave_o, tick_o, busy_o;
    logic [19:0] max_q_o;

    int n_chk  = 0;
    int n_fail = 0;

    // model: position within the full 2*mq period, 0 at the start of the low level
    bit m_run;
    int m_pos;
    int m_mq;

    tone_oscillator dut (
        .clk    (tb_clk),
        .nRst   (nRst),
        .en_i   (en_i),
        .max_i  (max_i),
        .wave_o (wave_o),
        .tick_o (tick_o),
        .busy_o (busy_o),
        .max_q_o(max_q_o)
    );

    always #5 tb_clk = ~tb_clk;

    function automatic bit exp_wave();
        return m_run && (m_pos >= m_mq);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0;
        m_pos = 0;
        m_mq  = 0;
    endtask

    task automatic model_step(input bit en, input int mx);
        if (!m_run) begin
            if (en && mx != 0) begin
                m_run = 1;
                m_mq  = mx;
                m_pos = 0;
            end
        end else if (!en) begin
            m_run = 0;
            m_pos = 0;
        end else begin
            m_pos++;
            if (m_pos == 2 * m_mq) begin
                m_pos = 0;
                if (mx != 0) m_mq = mx;
                else         m_run = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wave"}, 32'(wave_o), 32'(exp_wave()));
        chk({tag, ".tick"}, 32'(tick_o), 32'(m_run && m_pos == m_mq));
        chk({tag, ".busy"}, 32'(busy_o), 32'(m_run));
        chk({tag, ".maxq"}, 32'(max_q_o), 32'(m_mq));
    endtask

    task automatic cycle(input bit en, input int mx, input string tag);
        en_i  = en;
        max_i = 20'(mx);
        @(posedge tb_clk);
        if (nRst) model_step(en, mx);
        #1;
        check_all(tag);
    endtask

    initial begin
        nRst  = 1'b0;
        en_i  = 1'b0;
        max_i = '0;
        model_reset();
        #12;
        check_all("reset");
        nRst = 1'b1;

        // basic tone, max 4
        for (int i = 0; i < 20; i++) cycle(1, 4, "basic4");

        // note change while high: current level still lasts 4
        for (int i = 0; i < 16 && !exp_wave(); i++) cycle(1, 4, "seek_hi");
        for (int i = 0; i < 20; i++) cycle(1, 2, "chg2");

        // drop enable mid-high level
        for (int i = 0; i < 8 && !exp_wave(); i++) cycle(1, 2, "seek_hi2");
        cycle(0, 2, "dis");
        chk("dis.busy_now", 32'(busy_o), 32'd0);

        // rest from idle stays idle
        for (int i = 0; i < 10; i++) cycle(1, 0, "rest");

        // max_i = 0 while running finishes the period
        for (int i = 0; i < 5; i++) cycle(1, 3, "run3");
        for (int i = 0; i < 12; i++) cycle(1, 0, "drain");
        chk("drain.idle", 32'(busy_o), 32'd0);

        // minimum divisor
        for (int i = 0; i < 10; i++) cycle(1, 1, "min1");
        cycle(0, 0, "min1_off");

        // larger divisor through first rising edge
        for (int i = 0; i < 1300 && !exp_wave(); i++) cycle(1, 1000, "big");
        chk("big.rose", 32'(wave_o), 32'd1);
        chk("big.tick", 32'(tick_o), 32'd1);

        // async reset while high
        #2 nRst = 1'b0;
        #1;
        model_reset();
        check_all("areset");
        cycle(1, 3, "areset_hold");
        #2 nRst = 1'b1;
        for (int i = 0; i < 14; i++) cycle(1, 3, "post3");

        // en_i drop on the same edge as a falling toggle
        cycle(0, 0, "sim_off");
        for (int i = 0; i < 40 && !(m_run && m_pos == 2 * m_mq - 1); i++) cycle(1, 4, "sim_seek");
        cycle(0, 5, "sim_edge");
        chk("sim.maxq_not5", 32'(max_q_o), 32'd4);
        cycle(0, 5, "sim_after");

        // randomized
        begin
            int mx = 3;
            bit en = 1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 15) == 0) mx = $urandom_range(0, 6);
                if ($urandom_range(0, 31) == 0) en = ~en;
                cycle(en, mx, "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_oscillator.md
TONE_OSCILLATOR -- requirements
Module: tone_oscillator

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 nRst  input  1  asynchronous, active-low reset; assertion clears all state immediately, release is synchronous to clk.
REQ-003 en_i  input  1  oscillator enable; level-sensitive, sampled every clk edge.
REQ-004 max_i  input  20  half-period length in clk cycles, fed combinationally from note_div_table; 0 = silence/rest.
REQ-005 wave_o  output  1  registered square-wave output.
REQ-006 tick_o  output  1  registered one-cycle pulse, high in the cycle wave_o first reads 1 after each rising transition.
REQ-007 busy_o  output  1  registered; high while in RUN.
REQ-008 max_q_o  output  20  currently latched half-period, for observation and debug.

Function
REQ-009 Internal state: a two-state FSM {IDLE, RUN}, a 20-bit count register, and a 20-bit max_q register.
REQ-010 IDLE: wave_o=0, tick_o=0, busy_o=0, count=0; max_q holds its last value.
REQ-011 IDLE->RUN on the edge where en_i=1 and max_i!=0: latch max_q<=max_i, count<=0, wave<=0.
REQ-012 IDLE with en_i=0 or max_i=0: remain in IDLE, with no register changes.
REQ-013 RUN with en_i=0 at an edge: go to IDLE on that edge (wave<=0, count<=0, tick<=0), regardless of position in the period.
REQ-014 RUN, en_i=1, count!=max_q-1: count<=count+1; wave unchanged.
REQ-015 RUN, en_i=1, count==max_q-1: count<=0 and wave<=~wave, so each wave level lasts exactly max_q cycles and the full period is 2*max_q cycles.
REQ-016 Rising toggle (wave 0->1): tick<=1 for exactly one cycle; max_q is not reloaded.
REQ-017 Falling toggle (wave 1->0), which is the period boundary: if max_i!=0, max_q<=max_i; if max_i==0, go to IDLE.
REQ-018 A max_i change in mid-period takes effect only at the next period boundary. No partial-period glitches are allowed.
REQ-019 max_q==1: wave toggles every cycle (period 2 cycles), and tick_o pulses every 2 cycles.
REQ-020 Arithmetic: count is unsigned 20-bit. The compare against max_q-1 is only evaluated in RUN, where max_q>=1, so it never underflows.
REQ-021 busy_o = (state==RUN), registered with the state; max_q_o = max_q.
REQ-022 If en_i falls and a period boundary occur on the same edge, en_i has priority: go to IDLE, with no reload and no tick.

Reset
REQ-023 nRst=0 asynchronously forces: state=IDLE, count=0, max_q=0, wave_o=0, tick_o=0, busy_o=0, max_q_o=0.
REQ-024 Reset asserted mid-RUN: outputs go to their reset values without waiting for clk. After release, the block re-enters RUN only via REQ-011.

Verification
REQ-025 Basic tone: reset, then en_i=1, max_i=4 -> busy_o rises 1 cycle later; wave_o is 0 for 4 cycles and 1 for 4 cycles, repeating. tick_o pulses once every 8 cycles, coincident with the first high cycle of wave_o.
REQ-026 Note change mid-period: while running with max_i=4, change max_i to 2 while wave_o=1 -> the current high level still lasts 4 cycles. Thereafter wave_o is 2 low / 2 high, and max_q_o reads 2 from the boundary onward.
REQ-027 Disable and rest:
- Drop en_i mid-high-level -> the next cycle gives wave_o=0 and busy_o=0.
- Holding en_i=1 with max_i=0 from IDLE -> the block stays IDLE indefinitely.
- Setting max_i=0 while running -> the block completes the current period, then goes IDLE.
REQ-028 Minimum divisor: max_i=1 -> wave_o alternates every cycle and tick_o pulses every 2 cycles. Separately, max_i=20'h954E9 -> the first rising edge of wave_o occurs exactly 611561 cycles after entry to RUN.
REQ-029 Async reset: assert nRst between clk edges while wave_o=1 -> wave_o, busy_o and max_q_o read 0 before the next clk edge. After release with en_i=1 and max_i=3 -> normal 3/3 operation resumes.
REQ-030 Simultaneous events: drive en_i=0 on the same edge as a falling toggle, with max_i=5 -> IDLE, max_q_o is not updated to 5, and no tick_o pulse occurs.
